alu_cmd_sequencer: RTL and testbench

//  Byte-serial command front end for the 32-bit ALU (4-bit OPCODE; NZVC + Error flags).
//  - Assembles operand A, operand B and the opcode from an 8-bit valid/ready stream.
//  - Drives the ALU's combinational inputs and registers its Result and flags.
//  - Presents one response per command on a valid/ready output port.

---
 rtl/alu_cmd_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Byte-serial command front end for a 32-bit ALU: loads A, B and opcode from an
// 8-bit valid/ready stream and returns one registered response per command.
// Optional partial-command idle timeout is enabled by defining ALU_CMD_TIMEOUT_EN.
module alu_cmd_sequencer #(
`ifdef ALU_CMD_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYC = 1024,
`endif
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [31:0]      alu_result,
  input  logic [4:0]       alu_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_flags,
  output logic [CNT_W-1:0] cmd_count,
  output logic             abort
);

  localparam logic [2:0] LOAD_A  = 3'd0;
  localparam logic [2:0] LOAD_B  = 3'd1;
  localparam logic [2:0] LOAD_OP = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic             rsv_q, rsv_d;
  logic [31:0]      res_q, res_d;
  logic [4:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             loading, accept, timeout;

  assign loading  = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_OP);
  // Gated by rst so no byte is ever offered a ready while reset is held.
  assign in_ready = loading & ~rst;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rsv_d   = rsv_q;
    res_d   = res_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOAD_A: if (accept) begin
        a_d[{bcnt_q, 3'b000} +: 8] = in_data;
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) state_d = LOAD_B;
      end
      LOAD_B: if (accept) begin
        b_d[{bcnt_q, 3'b000} +: 8] = in_data;
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) state_d = LOAD_OP;
      end
      LOAD_OP: if (accept) begin
        op_d    = in_data[3:0];
        rsv_d   = |in_data[7:4];
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = alu_result;
        flags_d = {alu_flags[4] | rsv_q, alu_flags[3:0]};
        state_d = RESP;
      end
      RESP: if (out_ready) begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = LOAD_A;
      end
      default: state_d = LOAD_A;
    endcase
    if (timeout) begin
      state_d = LOAD_A;
      bcnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_A;
      bcnt_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rsv_q   <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rsv_q   <= rsv_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ALU_CMD_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              started, abort_q;

  // A command is "started" once any byte has been taken; before that, waiting is not idling.
  assign started = loading && !((state_q == LOAD_A) && (bcnt_q == 2'd0));

  always_comb begin
    idle_d  = '0;
    timeout = 1'b0;
    if (started && !accept) begin
      if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) timeout = 1'b1;
      else                                    idle_d  = idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      abort_q <= timeout;
    end
  end

  assign abort = abort_q;
`else
  assign timeout = 1'b0;
  assign abort   = 1'b0;
`endif

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign out_valid  = (state_q == RESP);
  assign out_result = res_q;
  assign out_flags  = flags_q;
  assign cmd_count  = cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small behavioural ALU
// (op 0 = add, op 8 = sub, anything else = error) closing the loop.
module tb_alu_cmd_sequencer;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic [31:0]      alu_a, alu_b;
  logic [3:0]       alu_opcode;
  logic [31:0]      alu_result;
  logic [4:0]       alu_flags;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [4:0]       out_flags;
  logic [CNT_W-1:0] cmd_count;
  logic             abort;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [CNT_W-1:0] exp_cnt;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
`ifdef ALU_CMD_TIMEOUT_EN
    .TIMEOUT_CYC(16),
`endif
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .cmd_count(cmd_count), .abort(abort)
  );

  // Behavioural ALU: flags are {Error,N,Z,V,C}; C on sub means borrow.
  logic [32:0] sum;
  logic        f_e, f_v, f_c;
  always_comb begin
    sum        = '0;
    alu_result = '0;
    f_e        = 1'b0;
    f_v        = 1'b0;
    f_c        = 1'b0;
    case (alu_opcode)
      4'h0: begin
        sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum[31:0];
        f_v        = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
        f_c        = sum[32];
      end
      4'h8: begin
        alu_result = alu_a - alu_b;
        f_v        = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
        f_c        = (alu_a < alu_b);
      end
      default: f_e = 1'b1;
    endcase
    alu_flags = {f_e, alu_result[31], alu_result == 32'd0, f_v, f_c};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      $error("%s differs", tag);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int unsigned g = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
    logic [31:0] av, bv;
    av = a;
    bv = b;
    for (int i = 0; i < 4; i++) send_byte(av[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(bv[8*i +: 8]);
    send_byte(op);
  endtask

  // Entered at the negedge inside EXEC (one cycle after the last byte).
  task automatic take_resp(input string tag, input logic [31:0] res, input logic [4:0] fl);
    check({tag, "_valid_exec"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"},  32'(out_valid), 32'd1);
    check({tag, "_result"}, out_result, res);
    check({tag, "_flags"},  32'(out_flags), 32'(fl));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt++;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_count"}, 32'(cmd_count), 32'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned ab_cnt, ab_first;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    exp_cnt   = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    out_result, 32'd0);
    check("rst_flags",     32'(out_flags), 32'd0);
    check("rst_count",     32'(cmd_count), 32'd0);
    check("rst_alu_a",     alu_a, 32'd0);
    check("rst_abort",     32'(abort), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // 1: add 1 + 2
    send_cmd(32'd1, 32'd2, 8'h00);
    check("t1_alu_a", alu_a, 32'd1);
    check("t1_alu_b", alu_b, 32'd2);
    check("t1_op",    32'(alu_opcode), 32'd0);
    take_resp("t1", 32'h0000_0003, 5'b00000);

    // 2: sub overflow
    send_cmd(32'h8000_0000, 32'h0000_0001, 8'h08);
    check("t2_alu_a", alu_a, 32'h8000_0000);
    take_resp("t2", 32'h7FFF_FFFF, 5'b00010);

    // 3: bad opcode, then nonzero reserved nibble
    send_cmd(32'd5, 32'd5, 8'h09);
    take_resp("t3a", 32'h0, 5'b10100);
    send_cmd(32'd1, 32'd1, 8'h10);
    check("t3b_op", 32'(alu_opcode), 32'd0);
    take_resp("t3b", 32'h2, 5'b10000);

    // 4: backpressure with a byte pending on the input
    send_cmd(32'h10, 32'h20, 8'h00);
    @(negedge clk);
    check("t4_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid",  32'(out_valid), 32'd1);
      check("t4_hold_result", out_result, 32'h30);
      check("t4_hold_ready",  32'(in_ready), 32'd0);
      check("t4_hold_alu_a",  alu_a, 32'h10);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt++;
    check("t4_valid_drop", 32'(out_valid), 32'd0);
    check("t4_count",      32'(cmd_count), 32'(exp_cnt));
    check("t4_not_yet",    alu_a, 32'h10);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_first_byte", alu_a, 32'h0000_00AA);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00);
    take_resp("t4", 32'hAB, 5'b00000);

    // 5: idle after a partial command
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    ab_cnt   = 0;
    ab_first = 0;
`ifdef ALU_CMD_TIMEOUT_EN
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (abort) begin
        if (ab_cnt == 0) ab_first = i;
        ab_cnt++;
      end
    end
    check("t5_abort_pulses", ab_cnt, 32'd1);
    check("t5_abort_cycle",  ab_first, 32'd16);
    send_cmd(32'd7, 32'd1, 8'h00);
    check("t5_alu_a", alu_a, 32'd7);
    take_resp("t5", 32'h8, 5'b00000);
`else
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (abort) ab_cnt++;
    end
    check("t5_no_abort", ab_cnt, 32'd0);
    check("t5_waiting",  32'(in_ready), 32'd1);
    send_byte(8'h00);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00);
    check("t5_alu_a", alu_a, 32'd1);
    take_resp("t5", 32'h3, 5'b00000);
`endif

    // 6: reset in the middle of loading B
    send_byte(8'h09); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h04);
    rst = 1'b1;
    #1;
    check("t6_alu_a",   alu_a, 32'd0);
    check("t6_alu_b",   alu_b, 32'd0);
    check("t6_result",  out_result, 32'd0);
    check("t6_count",   32'(cmd_count), 32'd0);
    check("t6_ready",   32'(in_ready), 32'd0);
    check("t6_valid",   32'(out_valid), 32'd0);
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_cmd(32'd5, 32'd3, 8'h08);
    take_resp("t6", 32'h2, 5'b00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
